regs_wport_ctrl: RTL
====================

Name: regs_wport_ctrl

Overview:
- Write-port controller placed directly in front of the general-purpose register file.
- After reset, scrubs x1..x(REG_NUM-1) to zero while holding the pipeline.
- Then arbitrates the single write port between ex writeback (fixed priority) and JTAG debug writes.
- JTAG writes are buffered and acknowledged, never silently dropped; a starvation counter requests a pipeline hold when JTAG waits too long.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
ADDR_W, 5, register address width, log2(REG_NUM)
DATA_W, 32, register data width
STARVE_MAX, 8, cycles a pending JTAG write may lose to ex before hold_ex_o asserts (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
ex_we_i  in  1  ex writeback enable
ex_waddr_i  in  ADDR_W  ex writeback address
ex_wdata_i  in  DATA_W  ex writeback data
jtag_req_i  in  1  JTAG write request, level, held until ack
jtag_addr_i  in  ADDR_W  JTAG write address, stable while req
jtag_data_i  in  DATA_W  JTAG write data, stable while req
jtag_ack_o  out  1  one-cycle registered pulse: JTAG write committed
init_busy_o  out  1  scrub in progress; pipeline must hold, ex_we_i must be 0
hold_ex_o  out  1  request ctrl to suppress ex writeback so JTAG can be granted
we_o  out  1  write enable to register file
waddr_o  out  ADDR_W  write address to register file
wdata_o  out  DATA_W  write data to register file

Behaviour:
- Clock clk, reset rst; reset is asynchronous and active-high. While rst=1: state=S_INIT, scrub idx=1, wait_cnt=0, buffer cleared, jtag_ack_o=0, hold_ex_o=0, init_busy_o=1, we_o=0, waddr_o=0, wdata_o=0.
- we_o/waddr_o/wdata_o are combinational from state and inputs. The register file commits on the same edge (zero added latency).
- FSM states: S_INIT, S_IDLE, S_PEND.
- S_INIT:
  - Drive we_o=1, waddr_o=idx, wdata_o=0; idx increments each cycle.
  - The cycle that writes idx=REG_NUM-1 transitions to S_IDLE. Scrub takes exactly REG_NUM-1 cycles after reset release.
  - init_busy_o=1 throughout; it is 0 from the first S_IDLE cycle.
  - ex_we_i is ignored in S_INIT (protocol violation, flag in assertions).
  - jtag_req_i is not captured in S_INIT.
- S_IDLE:
  - Port passes ex: we_o = ex_we_i and (ex_waddr_i != 0).
  - If jtag_req_i=1 and jtag_ack_o=0: latch jtag_addr_i/jtag_data_i into the buffer, go to S_PEND. This capture happens even in a cycle where ex writes; ex still owns the port that cycle.
- S_PEND:
  - If ex_we_i=1: ex owns the port; wait_cnt increments, saturating at STARVE_MAX.
  - If ex_we_i=0: grant JTAG. we_o = (buf_addr != 0), waddr_o=buf_addr, wdata_o=buf_data. Next cycle: jtag_ack_o=1, wait_cnt=0, state=S_IDLE.
- hold_ex_o = (state==S_PEND) and (wait_cnt==STARVE_MAX), registered. It clears the cycle after the grant.
- If ex_we_i stays 1 while hold_ex_o=1, ex still wins. ex writes are never dropped or delayed.
- JTAG address 0: write is suppressed (we_o=0) but the grant still occurs and jtag_ack_o still pulses.
- Handshake: master deasserts jtag_req_i in the cycle after it sees jtag_ack_o. The jtag_ack_o=1 cycle blocks recapture, so one request yields exactly one write.
- Only one JTAG write is outstanding at a time; no additional queueing.
- Reset asserted mid-scrub or mid-pend: outputs go to reset values immediately, the buffer is discarded with no ack, and the scrub restarts at idx 1 after release.

Test Plan:
1. Release rst -> cycles 1..31: we_o=1, waddr_o=1..31, wdata_o=0; init_busy_o=1 through cycle 31, 0 at cycle 32; never waddr_o=0.
2. After init, ex idle, jtag_req_i=1, addr=5, data=0xDEADBEEF at cycle T -> captured T; we_o=1, waddr_o=5, wdata_o=0xDEADBEEF at T+1; jtag_ack_o=1 only at T+2; one write total.
3. JTAG pending addr=7 while ex_we_i=1 every cycle -> hold_ex_o rises after 8 lost cycles. Drop ex_we_i -> JTAG write to 7 that cycle, ack next cycle, hold_ex_o=0 next cycle.
4. Same-cycle ex write (addr 3, 0x11) and new JTAG request (addr 3, 0x22) -> ex write first; JTAG write next free cycle; final x3=0x22.
5. JTAG request addr=0, data=0xFFFFFFFF -> we_o stays 0, jtag_ack_o pulses once.
6. Assert rst when idx=10, release -> outputs zero during reset; scrub restarts at waddr_o=1 and completes 31 cycles later.

Source files
------------

// File: rtl/regs_wport_ctrl.sv
// Write-port controller in front of the GPR file: post-reset scrub of x1..x(REG_NUM-1),
// then fixed-priority arbitration between ex writeback and a single buffered JTAG write.
module regs_wport_ctrl #(
  parameter int REG_NUM    = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              jtag_req_i,
  input  logic [ADDR_W-1:0] jtag_addr_i,
  input  logic [DATA_W-1:0] jtag_data_i,
  output logic              jtag_ack_o,
  output logic              init_busy_o,
  output logic              hold_ex_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_PEND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              jtag_ack_q, jtag_ack_d;
  logic              hold_ex_q, hold_ex_d;
  logic              init_busy_q, init_busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      idx_q       <= ADDR_W'(1);
      wait_cnt_q  <= {CNT_W{1'b0}};
      buf_addr_q  <= {ADDR_W{1'b0}};
      buf_data_q  <= {DATA_W{1'b0}};
      jtag_ack_q  <= 1'b0;
      hold_ex_q   <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      jtag_ack_q  <= jtag_ack_d;
      hold_ex_q   <= hold_ex_d;
      init_busy_q <= init_busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    jtag_ack_d = 1'b0;
    case (state_q)
      S_INIT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        // The ack cycle blocks recapture of the still-asserted request.
        if (jtag_req_i && !jtag_ack_q) begin
          buf_addr_d = jtag_addr_i;
          buf_data_d = jtag_data_i;
          state_d    = S_PEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PEND: begin
        if (ex_we_i) begin
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end else begin
          jtag_ack_d = 1'b1;
          wait_cnt_d = {CNT_W{1'b0}};
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
    // Derived from next-state values so hold drops in the cycle right after the grant.
    hold_ex_d   = (state_d == S_PEND) && (wait_cnt_d == CNT_MAX);
    init_busy_d = (state_d == S_INIT);
  end

  always_comb begin
    we_o    = 1'b0;
    waddr_o = {ADDR_W{1'b0}};
    wdata_o = {DATA_W{1'b0}};
    if (rst) begin
      we_o    = 1'b0;
      waddr_o = {ADDR_W{1'b0}};
      wdata_o = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        S_INIT: begin
          we_o    = 1'b1;
          waddr_o = idx_q;
          wdata_o = {DATA_W{1'b0}};
        end
        S_IDLE: begin
          we_o    = ex_we_i && (ex_waddr_i != ADDR_ZERO);
          waddr_o = ex_waddr_i;
          wdata_o = ex_wdata_i;
        end
        S_PEND: begin
          if (ex_we_i) begin
            we_o    = ex_waddr_i != ADDR_ZERO;
            waddr_o = ex_waddr_i;
            wdata_o = ex_wdata_i;
          end else begin
            we_o    = buf_addr_q != ADDR_ZERO;
            waddr_o = buf_addr_q;
            wdata_o = buf_data_q;
          end
        end
        default: begin
          we_o    = 1'b0;
          waddr_o = {ADDR_W{1'b0}};
          wdata_o = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign jtag_ack_o  = jtag_ack_q;
  assign hold_ex_o   = hold_ex_q;
  assign init_busy_o = init_busy_q;

endmodule
